uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 149 ++++++++++++++
 tb/tb_uart_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver that pushes each good byte into the downstream RX FIFO.
// Latency: write_req is high in the cycle after edge E0+2+HalfBit+(DataBitsSize+1)*ClksPerBit (E0 = first edge sampling rx low).
// Backpressure: none on the line; if fifo_full is set at the stop decision the byte is dropped and overrun pulses.
module uart_rx #(
   parameter int ClksPerBit   = 434,
   parameter int DataBitsSize = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rx,
   input  logic                    fifo_full,
   output logic                    write_req,
   output logic [DataBitsSize-1:0] data,
   output logic                    frame_err,
   output logic                    overrun,
   output logic                    busy
);

   localparam int HalfBit = ClksPerBit / 2;
   localparam int CntW    = $clog2(ClksPerBit);
   localparam int IdxW    = (DataBitsSize > 1) ? $clog2(DataBitsSize) : 1;

   localparam logic [CntW-1:0] LastCnt = CntW'(ClksPerBit - 1);
   localparam logic [CntW-1:0] HalfCnt = CntW'(HalfBit - 1);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(DataBitsSize - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } state_t;

   logic [1:0]              sync_q;
   logic                    rx_s;
   state_t                  state_q;
   logic [CntW-1:0]         cnt_q;
   logic [IdxW-1:0]         bit_idx_q;
   logic [DataBitsSize-1:0] shift_q;
   logic [DataBitsSize-1:0] data_q;
   logic                    write_req_q;
   logic                    frame_err_q;
   logic                    overrun_q;

   // Two-flop synchroniser; resets to the idle-high line level so reset release never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx};
      end
   end

   assign rx_s = sync_q[1];

   // Frame FSM: mid-bit sampling, stop-bit decision and the registered one-cycle status strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         write_req_q <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         // Strobes default low so each one lasts exactly one cycle.
         write_req_q <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q     <= '0;
               bit_idx_q <= '0;
               if (!rx_s) begin
                  state_q <= START;
               end
            end
            START: begin
               if (cnt_q == HalfCnt) begin
                  cnt_q     <= '0;
                  bit_idx_q <= '0;
                  // Still low at mid start bit: a real frame; otherwise a glitch, silently ignored.
                  state_q   <= rx_s ? IDLE : DATA;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            DATA: begin
               if (cnt_q == LastCnt) begin
                  cnt_q              <= '0;
                  shift_q[bit_idx_q] <= rx_s;
                  if (bit_idx_q == LastIdx) begin
                     bit_idx_q <= '0;
                     state_q   <= STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + IdxW'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            STOP: begin
               if (cnt_q == LastCnt) begin
                  cnt_q     <= '0;
                  bit_idx_q <= '0;
                  if (rx_s) begin
                     // Leave mid stop bit so a back-to-back start edge is not missed.
                     state_q <= IDLE;
                     if (fifo_full) begin
                        overrun_q <= 1'b1;
                     end else begin
                        data_q      <= shift_q;
                        write_req_q <= 1'b1;
                     end
                  end else begin
                     // Low stop bit: report once, then wait out any break before rearming.
                     frame_err_q <= 1'b1;
                     state_q     <= WAIT_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            WAIT_IDLE: begin
               cnt_q     <= '0;
               bit_idx_q <= '0;
               if (rx_s) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q   <= IDLE;
               cnt_q     <= '0;
               bit_idx_q <= '0;
            end
         endcase
      end
   end

   assign write_req = write_req_q;
   assign data      = data_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Purpose: directed checks of uart_rx with ClksPerBit=16 (HalfBit=8, stop decision at E0+154).
// Latency: all stimulus is cycle-exact; every wait is a fixed repeat count.
// Backpressure: fifo_full is driven per table vector to provoke overrun.
module tb_uart_rx;

   localparam int Cpb      = 16;
   localparam int StopEdge = 2 + Cpb / 2 + 9 * Cpb;  // 154

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic       fifo_full;
   logic       write_req;
   logic [7:0] data;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int         wr_n = 0;
   int         fe_n = 0;
   int         ov_n = 0;
   int         wr_cyc[$];
   logic [7:0] wr_dat[$];
   logic       prev_any = 1'b0;

   uart_rx #(.ClksPerBit(Cpb), .DataBitsSize(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .fifo_full (fifo_full),
      .write_req (write_req),
      .data      (data),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter: after posedge number n, cyc == n.
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   // Monitor: log strobes and check exclusivity / single-cycle width whenever one is seen.
   always @(negedge clk) begin
      logic any;
      any = write_req | frame_err | overrun;
      if (any) begin
         chk("strobe_exclusive", int'(write_req) + int'(frame_err) + int'(overrun), 1);
         chk("strobe_one_cycle", int'(prev_any), 0);
      end
      if (write_req) begin
         wr_n++;
         wr_cyc.push_back(cyc);
         wr_dat.push_back(data);
      end
      if (frame_err) fe_n++;
      if (overrun)   ov_n++;
      prev_any = any;
   end

   // Called at a negedge; returns at the negedge ending the stop bit with rx still at stop_bit.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int e0);
      rx = 1'b0;
      e0 = cyc + 1;
      repeat (Cpb) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (Cpb) @(negedge clk);
      end
      rx = stop_bit;
      repeat (Cpb) @(negedge clk);
   endtask

   task automatic check_write(input string nm, input int e0, input logic [7:0] exp, input int wr_before);
      chk({nm, "_wr_count"}, wr_n - wr_before, 1);
      if (wr_n > wr_before) begin
         chk({nm, "_wr_cycle"}, wr_cyc[wr_before], e0 + StopEdge);
         chk({nm, "_wr_data"}, int'(wr_dat[wr_before]), int'(exp));
      end
   endtask

   typedef struct {
      logic [7:0] byte_v;
      logic       full;
      int         exp_wr;
      int         exp_ov;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int e0, e1, e2, w0, f0, o0;

      vecs[0] = '{byte_v: 8'hA5, full: 1'b0, exp_wr: 1, exp_ov: 0, exp_data: 8'hA5};
      vecs[1] = '{byte_v: 8'h11, full: 1'b0, exp_wr: 1, exp_ov: 0, exp_data: 8'h11};
      vecs[2] = '{byte_v: 8'h77, full: 1'b1, exp_wr: 0, exp_ov: 1, exp_data: 8'h11};
      vecs[3] = '{byte_v: 8'h78, full: 1'b0, exp_wr: 1, exp_ov: 0, exp_data: 8'h78};

      rst_n     = 1'b0;
      rx        = 1'b1;
      fifo_full = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", int'({write_req, frame_err, overrun, busy, data}), 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("idle_busy", int'(busy), 0);

      // Table: single frames, including the overrun case and its recovery.
      foreach (vecs[k]) begin
         w0 = wr_n; f0 = fe_n; o0 = ov_n;
         fifo_full = vecs[k].full;
         send_frame(vecs[k].byte_v, 1'b1, e0);
         fifo_full = 1'b0;
         repeat (10) @(negedge clk);
         if (vecs[k].exp_wr == 1) begin
            check_write($sformatf("vec%0d", k), e0, vecs[k].exp_data, w0);
         end else begin
            chk($sformatf("vec%0d_no_write", k), wr_n - w0, 0);
         end
         chk($sformatf("vec%0d_overrun", k), ov_n - o0, vecs[k].exp_ov);
         chk($sformatf("vec%0d_frame_err", k), fe_n - f0, 0);
         chk($sformatf("vec%0d_data_held", k), int'(data), int'(vecs[k].exp_data));
         chk($sformatf("vec%0d_busy", k), int'(busy), 0);
      end

      // Back-to-back frames with no idle gap.
      w0 = wr_n;
      send_frame(8'h00, 1'b1, e0);
      send_frame(8'hFF, 1'b1, e1);
      send_frame(8'h3C, 1'b1, e2);
      repeat (10) @(negedge clk);
      chk("b2b_count", wr_n - w0, 3);
      if (wr_n - w0 == 3) begin
         chk("b2b_cyc0", wr_cyc[w0], e0 + StopEdge);
         chk("b2b_gap1", wr_cyc[w0 + 1] - wr_cyc[w0], 160);
         chk("b2b_gap2", wr_cyc[w0 + 2] - wr_cyc[w0 + 1], 160);
         chk("b2b_dat0", int'(wr_dat[w0]), 8'h00);
         chk("b2b_dat1", int'(wr_dat[w0 + 1]), 8'hFF);
         chk("b2b_dat2", int'(wr_dat[w0 + 2]), 8'h3C);
      end

      // 5-cycle glitch: must be rejected at mid start bit.
      w0 = wr_n; f0 = fe_n; o0 = ov_n;
      rx = 1'b0;
      repeat (5) @(negedge clk);
      chk("glitch_busy_high", int'(busy), 1);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      chk("glitch_busy_low", int'(busy), 0);
      chk("glitch_no_events", (wr_n - w0) + (fe_n - f0) + (ov_n - o0), 0);
      send_frame(8'h55, 1'b1, e0);
      repeat (10) @(negedge clk);
      check_write("after_glitch", e0, 8'h55, w0);

      // Low stop bit followed by a long break.
      w0 = wr_n; f0 = fe_n;
      send_frame(8'h12, 1'b0, e0);
      repeat (400) @(negedge clk);
      chk("break_frame_err", fe_n - f0, 1);
      chk("break_no_write", wr_n - w0, 0);
      chk("break_busy", int'(busy), 1);
      chk("break_data_kept", int'(data), 8'h55);
      rx = 1'b1;
      repeat (6) @(negedge clk);
      chk("break_release_busy", int'(busy), 0);
      w0 = wr_n;
      send_frame(8'h34, 1'b1, e0);
      repeat (10) @(negedge clk);
      check_write("after_break", e0, 8'h34, w0);
      chk("after_break_fe", fe_n - f0, 1);

      // Reset asserted after data bit 3 of a frame.
      w0 = wr_n;
      rx = 1'b0;
      repeat (Cpb) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = ~rx;
         repeat (Cpb) @(negedge clk);
      end
      chk("midframe_busy", int'(busy), 1);
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      chk("midframe_reset_outputs", int'({write_req, frame_err, overrun, busy, data}), 0);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      chk("aborted_no_write", wr_n - w0, 0);
      chk("aborted_busy", int'(busy), 0);
      send_frame(8'h9C, 1'b1, e0);
      repeat (10) @(negedge clk);
      check_write("after_reset", e0, 8'h9C, w0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
